// File: rtl/hazard_scoreboard_if.sv
// ID-stage request and EX forwarding/stall response bundle for the hazard scoreboard.
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 3
);
    localparam int FWD_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  id_valid_i;
    logic [REG_ADDR_W-1:0] id_rs_i;
    logic [REG_ADDR_W-1:0] id_rt_i;
    logic                  id_use_rs_i;
    logic                  id_use_rt_i;
    logic [REG_ADDR_W-1:0] id_rd_i;
    logic                  id_regwrite_i;
    logic                  id_memread_i;
    logic                  flush_i;
    logic                  hold_i;
    logic                  stall_o;
    logic [FWD_W-1:0]      fwd_a_o;
    logic [FWD_W-1:0]      fwd_b_o;
    logic [CNT_W-1:0]      inflight_o;

    modport master (
        output id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
               id_rd_i, id_regwrite_i, id_memread_i, flush_i, hold_i,
        input  stall_o, fwd_a_o, fwd_b_o, inflight_o
    );

    modport slave (
        input  id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
               id_rd_i, id_regwrite_i, id_memread_i, flush_i, hold_i,
        output stall_o, fwd_a_o, fwd_b_o, inflight_o
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Shift scoreboard tracking in-flight producers from EX to writeback; drives ID stall and EX forward selects.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_AVAIL = 2,
    parameter int ALU_AVAIL  = 1,
    parameter int FWD_W      = $clog2(DEPTH)
) (
    input logic               clk_i,
    input logic               rst_i,
    hazard_scoreboard_if.slave sb
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic [FWD_W-1:0]      avail;
        logic                  use_rs;
        logic                  use_rt;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
    } entry_t;

    entry_t ent [DEPTH];
    entry_t issue_ent;
    logic   id_hazard;
    logic   issue;
    logic   late_a, late_b;
    logic   found_a, found_b;
    logic [FWD_W-1:0] fwd_a, fwd_b;
    logic [CNT_W-1:0] cnt;

    function automatic logic hit(entry_t e, logic [REG_ADDR_W-1:0] s, logic use_s);
        return e.valid && e.regwrite && (e.rd == s) && (s != '0) && use_s;
    endfunction

    // A producer in stage k reaches its forwarding point in (avail - k) cycles; stall while that exceeds 1.
    always_comb begin
        id_hazard = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((hit(ent[k], sb.id_rs_i, sb.id_use_rs_i) ||
                 hit(ent[k], sb.id_rt_i, sb.id_use_rt_i)) &&
                (k + 1 < int'(ent[k].avail)))
                id_hazard = 1'b1;
        end
    end

    assign sb.stall_o = sb.hold_i || (sb.id_valid_i && !sb.flush_i && id_hazard);
    assign issue      = sb.id_valid_i && !sb.flush_i && !id_hazard;

    // Youngest matching producer wins; if it is not yet forwardable the select falls back to 0.
    always_comb begin
        fwd_a   = '0;
        fwd_b   = '0;
        found_a = 1'b0;
        found_b = 1'b0;
        late_a  = 1'b0;
        late_b  = 1'b0;
        for (int k = 1; k < DEPTH; k++) begin
            if (!found_a && hit(ent[k], ent[0].rs, ent[0].use_rs)) begin
                found_a = 1'b1;
                if (k >= int'(ent[k].avail)) fwd_a = FWD_W'(k);
                else                         late_a = 1'b1;
            end
            if (!found_b && hit(ent[k], ent[0].rt, ent[0].use_rt)) begin
                found_b = 1'b1;
                if (k >= int'(ent[k].avail)) fwd_b = FWD_W'(k);
                else                         late_b = 1'b1;
            end
        end
    end

    assign sb.fwd_a_o = fwd_a;
    assign sb.fwd_b_o = fwd_b;

    always_comb begin
        cnt = '0;
        for (int k = 0; k < DEPTH; k++)
            if (ent[k].valid) cnt = cnt + CNT_W'(1);
    end

    assign sb.inflight_o = cnt;

    always_comb begin
        issue_ent          = '0;
        issue_ent.valid    = 1'b1;
        issue_ent.rd       = sb.id_rd_i;
        issue_ent.regwrite = sb.id_regwrite_i;
        issue_ent.avail    = sb.id_memread_i ? FWD_W'(LOAD_AVAIL) : FWD_W'(ALU_AVAIL);
        issue_ent.use_rs   = sb.id_use_rs_i;
        issue_ent.use_rt   = sb.id_use_rt_i;
        issue_ent.rs       = sb.id_rs_i;
        issue_ent.rt       = sb.id_rt_i;
    end

    // Bubbles are all-zero so a bubble in EX never requests forwarding.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < DEPTH; k++) ent[k] <= '0;
        end else if (!sb.hold_i) begin
            for (int k = DEPTH - 1; k > 0; k--) ent[k] <= ent[k-1];
            ent[0] <= issue ? issue_ent : '0;
        end
    end

    a_no_late_fwd: assert property (@(posedge clk_i) disable iff (rst_i) !(late_a || late_b));
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: default geometry (dut0) and DEPTH=5/LOAD_AVAIL=4/ALU_AVAIL=2 (dut1) on shared stimulus.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst0, rst1;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_ADDR_W(5), .DEPTH(3)) bus0 ();
    hazard_scoreboard_if #(.REG_ADDR_W(5), .DEPTH(5)) bus1 ();

    hazard_scoreboard #(.REG_ADDR_W(5), .DEPTH(3), .LOAD_AVAIL(2), .ALU_AVAIL(1))
        dut0 (.clk_i(clk), .rst_i(rst0), .sb(bus0));
    hazard_scoreboard #(.REG_ADDR_W(5), .DEPTH(5), .LOAD_AVAIL(4), .ALU_AVAIL(2))
        dut1 (.clk_i(clk), .rst_i(rst1), .sb(bus1));

    task automatic chk(input string tag, input int got, input int exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // valid, rs, rt, use_rs, use_rt, rd, regwrite, memread, flush, hold
    task automatic drv(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input int rd, input bit rw, input bit mr, input bit fl, input bit ho);
        bus0.id_valid_i = v;   bus1.id_valid_i = v;
        bus0.id_rs_i = 5'(rs); bus1.id_rs_i = 5'(rs);
        bus0.id_rt_i = 5'(rt); bus1.id_rt_i = 5'(rt);
        bus0.id_use_rs_i = urs; bus1.id_use_rs_i = urs;
        bus0.id_use_rt_i = urt; bus1.id_use_rt_i = urt;
        bus0.id_rd_i = 5'(rd); bus1.id_rd_i = 5'(rd);
        bus0.id_regwrite_i = rw; bus1.id_regwrite_i = rw;
        bus0.id_memread_i = mr;  bus1.id_memread_i = mr;
        bus0.flush_i = fl; bus1.flush_i = fl;
        bus0.hold_i = ho;  bus1.hold_i = ho;
        #1;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain(input int n);
        idle();
        for (int i = 0; i < n; i++) step();
    endtask

    int cnt;

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        idle();
        step();
        rst0 = 1'b0;
        rst1 = 1'b0;
        #1;

        // reset state
        chk("rst_inflight", int'(bus0.inflight_o), 0);
        chk("rst_fwd_a", int'(bus0.fwd_a_o), 0);
        chk("rst_fwd_b", int'(bus0.fwd_b_o), 0);
        chk("rst_stall", int'(bus0.stall_o), 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_stall_hold", int'(bus0.stall_o), 1);
        idle();

        // load-use: lw r5 ; add r6 = r5 + r1
        drv(1, 2, 0, 1, 0, 5, 1, 1, 0, 0);
        chk("lu_lw_nostall", int'(bus0.stall_o), 0);
        step();
        drv(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        chk("lu_stall1", int'(bus0.stall_o), 1);
        step();
        chk("lu_stall_end", int'(bus0.stall_o), 0);
        step();
        idle();
        chk("lu_fwd_a", int'(bus0.fwd_a_o), 2);
        chk("lu_fwd_b", int'(bus0.fwd_b_o), 0);
        chk("lu_inflight", int'(bus0.inflight_o), 2);
        drain(3);
        chk("drain_inflight", int'(bus0.inflight_o), 0);

        // ALU chain: add r3 ; sub r4 = r3 - r3 ; or r5 = r3 | r8
        drv(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
        step();
        drv(1, 3, 3, 1, 1, 4, 1, 0, 0, 0);
        chk("alu_nostall", int'(bus0.stall_o), 0);
        step();
        drv(1, 3, 8, 1, 1, 5, 1, 0, 0, 0);
        chk("alu_nostall2", int'(bus0.stall_o), 0);
        chk("alu_fwd_a1", int'(bus0.fwd_a_o), 1);
        chk("alu_fwd_b1", int'(bus0.fwd_b_o), 1);
        step();
        idle();
        chk("alu_fwd_a2", int'(bus0.fwd_a_o), 2);
        chk("alu_fwd_b2", int'(bus0.fwd_b_o), 0);
        chk("alu_inflight", int'(bus0.inflight_o), 3);
        drain(3);

        // youngest wins: two writes of r7, then read r7
        drv(1, 1, 2, 1, 1, 7, 1, 0, 0, 0);
        step();
        drv(1, 3, 4, 1, 1, 7, 1, 0, 0, 0);
        step();
        drv(1, 7, 0, 1, 0, 9, 1, 0, 0, 0);
        chk("yw_nostall", int'(bus0.stall_o), 0);
        step();
        idle();
        chk("yw_fwd_a", int'(bus0.fwd_a_o), 1);
        drain(3);

        // r0 producer/consumer
        drv(1, 1, 2, 1, 1, 0, 1, 1, 0, 0);
        step();
        drv(1, 0, 0, 1, 1, 6, 1, 0, 0, 0);
        chk("r0_nostall", int'(bus0.stall_o), 0);
        step();
        idle();
        chk("r0_fwd_a", int'(bus0.fwd_a_o), 0);
        chk("r0_fwd_b", int'(bus0.fwd_b_o), 0);
        drain(3);

        // unused rt matching a pending load
        drv(1, 2, 0, 1, 0, 9, 1, 1, 0, 0);
        step();
        drv(1, 1, 9, 1, 0, 6, 1, 0, 0, 0);
        chk("unused_nostall", int'(bus0.stall_o), 0);
        step();
        idle();
        chk("unused_fwd_b", int'(bus0.fwd_b_o), 0);
        chk("unused_fwd_a", int'(bus0.fwd_a_o), 0);
        drain(3);

        // flush of a dependent instruction
        drv(1, 2, 0, 1, 0, 5, 1, 1, 0, 0);
        step();
        drv(1, 5, 1, 1, 1, 6, 1, 0, 1, 0);
        chk("flush_nostall", int'(bus0.stall_o), 0);
        step();
        idle();
        chk("flush_inflight", int'(bus0.inflight_o), 1);
        chk("flush_fwd_a", int'(bus0.fwd_a_o), 0);
        drain(3);

        // hold freezes state
        drv(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
        step();
        drv(1, 3, 3, 1, 1, 4, 1, 0, 0, 0);
        step();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            chk("hold_stall", int'(bus0.stall_o), 1);
            chk("hold_inflight", int'(bus0.inflight_o), 2);
            chk("hold_fwd_a", int'(bus0.fwd_a_o), 1);
            chk("hold_fwd_b", int'(bus0.fwd_b_o), 1);
            step();
        end
        idle();
        chk("hold_release_fwd", int'(bus0.fwd_a_o), 1);
        step();
        chk("post_hold_inflight", int'(bus0.inflight_o), 2);
        chk("post_hold_fwd_a", int'(bus0.fwd_a_o), 0);
        drain(3);

        // DEPTH=5 geometry
        rst1 = 1'b1;
        step();
        rst1 = 1'b0;
        #1;
        chk("d5_rst_inflight", int'(bus1.inflight_o), 0);

        drv(1, 2, 0, 1, 0, 5, 1, 1, 0, 0);
        step();
        drv(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        cnt = 0;
        for (int i = 0; i < 10 && bus1.stall_o; i++) begin
            cnt++;
            step();
        end
        chk("d5_lu_stall_cycles", cnt, 3);
        step();
        idle();
        chk("d5_lu_fwd_a", int'(bus1.fwd_a_o), 4);
        chk("d5_lu_fwd_b", int'(bus1.fwd_b_o), 0);
        drain(5);

        drv(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
        step();
        drv(1, 3, 0, 1, 0, 4, 1, 0, 0, 0);
        cnt = 0;
        for (int i = 0; i < 10 && bus1.stall_o; i++) begin
            cnt++;
            step();
        end
        chk("d5_alu_stall_cycles", cnt, 1);
        step();
        idle();
        chk("d5_alu_fwd_a", int'(bus1.fwd_a_o), 2);
        drain(5);

        // reset in the middle of a load-use stall
        drv(1, 2, 0, 1, 0, 5, 1, 1, 0, 0);
        step();
        drv(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        chk("d5_pre_rst_stall", int'(bus1.stall_o), 1);
        rst1 = 1'b1;
        step();
        rst1 = 1'b0;
        #1;
        chk("d5_rst_mid_stall", int'(bus1.stall_o), 0);
        chk("d5_rst_mid_inflight", int'(bus1.inflight_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
